// File: rtl/apu_frame_sequencer_if.sv
// apu_frame_sequencer_if
//   Bundles the frame-sequencer signals that run between the register file,
//   the sequencer and the channel blocks.
//   master : register-file side. Drives the $4017 value, the write strobe and
//            the $4015 read strobe, and observes the sequencer outputs.
//   slave  : frame-sequencer side. Receives the register traffic and drives
//            the quarter/half-frame strobes, the frame IRQ and the step index.
interface apu_frame_sequencer_if;
  logic [7:0] reg_4017;        // bit 7 = mode (1 = 5-step), bit 6 = irq_inhibit
  logic       reg_event_4017;  // one-cycle strobe when $4017 is written
  logic       status_read;     // one-cycle strobe on a $4015 read
  logic       enable_240hz;    // quarter-frame strobe
  logic       enable_120hz;    // half-frame strobe
  logic       frame_irq;       // frame interrupt level
  logic [2:0] step;            // most recent step index, 0..4

  modport master (
    output reg_4017, reg_event_4017, status_read,
    input  enable_240hz, enable_120hz, frame_irq, step
  );

  modport slave (
    input  reg_4017, reg_event_4017, status_read,
    output enable_240hz, enable_120hz, frame_irq, step
  );
endinterface

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer
//   Paces the envelope and length-counter logic of the APU channels. A 16-bit
//   cycle counter runs at the CPU clock. Fixed positions in the frame produce
//   one-cycle quarter-frame and half-frame strobes, and the frame interrupt
//   in 4-step mode. A $4017 write restarts the frame. A write that selects
//   5-step mode also fires an immediate quarter+half strobe pair.
// Ports
//   clk   : CPU-rate clock (1.789773 MHz)
//   rst_n : asynchronous active-low reset
//   bus   : slave side of apu_frame_sequencer_if
//           inputs  reg_4017, reg_event_4017, status_read
//           outputs enable_240hz, enable_120hz, frame_irq, step (all registered)
module apu_frame_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  apu_frame_sequencer_if.slave bus
);

  // Step positions in CPU cycles from the start of a frame.
  localparam logic [15:0] QUARTER_1  = 16'd7456;
  localparam logic [15:0] QUARTER_2  = 16'd14912;
  localparam logic [15:0] QUARTER_3  = 16'd22370;
  localparam logic [15:0] LAST_4STEP = 16'd29828;
  localparam logic [15:0] LAST_5STEP = 16'd37280;
  localparam logic [15:0] WRAP_4STEP = 16'd29829;
  localparam logic [15:0] WRAP_5STEP = 16'd37281;

  logic [15:0] cycle_count_q, cycle_count_d;
  logic        mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic [2:0]  step_q, step_d;
  logic        quarter_q, quarter_d;
  logic        half_q, half_d;
  logic        irq_q, irq_d;

  logic [15:0] last_step;
  logic [15:0] wrap_point;
  logic        at_last;
  logic        irq_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      mode_q        <= 1'b0;
      inhibit_q     <= 1'b0;
      step_q        <= 3'd0;
      quarter_q     <= 1'b0;
      half_q        <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      mode_q        <= mode_d;
      inhibit_q     <= inhibit_d;
      step_q        <= step_d;
      quarter_q     <= quarter_d;
      half_q        <= half_d;
      irq_q         <= irq_d;
    end
  end

  // Next-state logic
  always_comb begin
    last_step  = mode_q ? LAST_5STEP : LAST_4STEP;
    wrap_point = mode_q ? WRAP_5STEP : WRAP_4STEP;
    at_last    = (cycle_count_q == last_step);
    irq_hit    = at_last && !mode_q && !inhibit_q;

    // '>=' rather than '==' so any out-of-range count also returns to 0.
    cycle_count_d = (cycle_count_q >= wrap_point) ? 16'd0 : cycle_count_q + 16'd1;
    mode_d        = mode_q;
    inhibit_d     = inhibit_q;
    step_d        = step_q;
    quarter_d     = 1'b0;
    half_d        = 1'b0;
    irq_d         = irq_q;

    if (bus.reg_event_4017) begin
      // The write takes priority over any step match in this cycle. The
      // match strobes and the IRQ set are dropped, and only the 5-step
      // immediate clock can appear.
      cycle_count_d = 16'd0;
      step_d        = 3'd0;
      mode_d        = bus.reg_4017[7];
      inhibit_d     = bus.reg_4017[6];
      quarter_d     = bus.reg_4017[7];
      half_d        = bus.reg_4017[7];
      if (bus.reg_4017[6] || bus.status_read) begin
        irq_d = 1'b0;
      end
    end else begin
      if (cycle_count_q >= wrap_point) begin
        step_d = 3'd0;
      end

      case (cycle_count_q)
        QUARTER_1: begin
          quarter_d = 1'b1;
          step_d    = 3'd1;
        end
        QUARTER_2: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          step_d    = 3'd2;
        end
        QUARTER_3: begin
          quarter_d = 1'b1;
          step_d    = 3'd3;
        end
        default: ;
      endcase

      if (at_last) begin
        quarter_d = 1'b1;
        half_d    = 1'b1;
        step_d    = 3'd4;
      end

      // A set in the same cycle as a $4015 read wins, so the read cannot
      // hide a new interrupt.
      if (irq_hit) begin
        irq_d = 1'b1;
      end else if (bus.status_read) begin
        irq_d = 1'b0;
      end
    end
  end

  // Outputs come straight from flops.
  assign bus.enable_240hz = quarter_q;
  assign bus.enable_120hz = half_q;
  assign bus.frame_irq    = irq_q;
  assign bus.step         = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer
//   Scoreboard bench. The stimulus process advances a frame-level reference
//   model once per clock and queues the outputs it expects. A separate monitor
//   pops one entry per clock and compares it whenever either side changes.
module tb_apu_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apu_frame_sequencer_if bus ();

  apu_frame_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       e240;
    logic       e120;
    logic [2:0] step;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the position within the frame, the latched
  // mode/inhibit, and the outputs expected after the next clock.
  int m_pos   = 0;
  bit m_mode  = 1'b0;
  bit m_inh   = 1'b0;
  bit m_irq   = 1'b0;
  int m_step  = 0;
  bit m_e240  = 1'b0;
  bit m_e120  = 1'b0;

  // Quarter-frame positions. The fourth position depends on the mode.
  function automatic int quarter_point(bit mode, int k);
    case (k)
      0:       return 7456;
      1:       return 14912;
      2:       return 22370;
      default: return mode ? 37280 : 29828;
    endcase
  endfunction

  function automatic int frame_len(bit mode);
    return mode ? 37282 : 29830;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_step = 0; m_e240 = 0; m_e120 = 0;
    end else if (bus.reg_event_4017) begin
      m_pos  = 0;
      m_step = 0;
      m_mode = bus.reg_4017[7];
      m_inh  = bus.reg_4017[6];
      m_e240 = m_mode;
      m_e120 = m_mode;
      if (bus.reg_4017[6] || bus.status_read) m_irq = 0;
    end else begin
      m_e240 = 0;
      m_e120 = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_pos == quarter_point(m_mode, k)) begin
          m_e240 = 1;
          m_e120 = (k == 1) || (k == 3);
          m_step = k + 1;
        end
      end
      if (!m_mode && !m_inh && m_pos == quarter_point(1'b0, 3)) m_irq = 1;
      else if (bus.status_read) m_irq = 0;
      if (m_pos == frame_len(m_mode) - 1) begin
        m_pos  = 0;
        m_step = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // One clock: predict, queue, then advance to just after the edge.
  task automatic tick();
    exp_t x;
    model_edge();
    x.e240 = m_e240;
    x.e120 = m_e120;
    x.step = 3'(m_step);
    x.irq  = m_irq;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int target);
    int guard = 0;
    while (m_pos != target && guard < 40000) begin
      tick();
      guard++;
    end
    if (m_pos != target) begin
      $display("FAIL run_to: model position %0d, required %0d", m_pos, target);
      $fatal(1, "bench sequencing error");
    end
  endtask

  task automatic write_4017(logic [7:0] d);
    bus.reg_4017       = d;
    bus.reg_event_4017 = 1'b1;
    tick();
    bus.reg_event_4017 = 1'b0;
  endtask

  // Monitor: one pop per clock, compared whenever expected or actual changes.
  initial begin
    exp_t e;
    exp_t a;
    exp_t prev_e = '0;
    exp_t prev_a = '0;
    int   cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      a.e240 = bus.enable_240hz;
      a.e120 = bus.enable_120hz;
      a.step = bus.step;
      a.irq  = bus.frame_irq;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: no expected entry queued", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != prev_e || a !== prev_a) begin
          n_checks++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got e240=%b e120=%b step=%0d irq=%b, expected e240=%b e120=%b step=%0d irq=%b",
                     cyc, a.e240, a.e120, a.step, a.irq, e.e240, e.e120, e.step, e.irq);
          end else begin
            $display("cycle %0d: e240=%b e120=%b step=%0d irq=%b ok", cyc, a.e240, a.e120, a.step, a.irq);
          end
        end
        prev_e = e;
        prev_a = a;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    bus.reg_4017       = 8'h00;
    bus.reg_event_4017 = 1'b0;
    bus.status_read    = 1'b0;
    rst_n              = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset-default 4-step frame. The $4015 read lands on the IRQ-set cycle,
    // so the set must win. A later read clears the flag.
    run_to(29828);
    bus.status_read = 1'b1;
    tick();
    bus.status_read = 1'b0;
    repeat (3) tick();
    bus.status_read = 1'b1;
    tick();
    bus.status_read = 1'b0;
    repeat (3) tick();

    // 5-step with an immediate clock, run through a full period and its wrap.
    write_4017(8'h80);
    run_to(37280);
    repeat (4) tick();
    run_to(2000);

    // Asynchronous reset between clock edges, in 5-step mode.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.enable_240hz, bus.enable_120hz, bus.step, bus.frame_irq} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: got e240=%b e120=%b step=%0d irq=%b, expected all 0",
               bus.enable_240hz, bus.enable_120hz, bus.step, bus.frame_irq);
    end
    repeat (2) tick();
    rst_n = 1'b1;

    // Back-to-back writes, each 5-step write with its own strobe pair.
    run_to(100);
    write_4017(8'hC0);
    write_4017(8'h80);
    write_4017(8'h40);
    run_to(300);
    write_4017(8'h00);

    // A write on a step match suppresses that strobe and restarts the frame.
    run_to(7456);
    write_4017(8'h00);
    run_to(7456);
    repeat (3) tick();

    // Random $4015 reads and occasional $4017 writes.
    for (int i = 0; i < 5000; i++) begin
      bus.status_read = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) begin
        bus.reg_4017       = 8'($urandom);
        bus.reg_event_4017 = 1'b1;
      end
      tick();
      bus.status_read    = 1'b0;
      bus.reg_event_4017 = 1'b0;
    end

    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

APU frame sequencer that paces the envelope and length-counter logic of all sound channels, including the noise channel. It counts CPU-rate clocks and emits single-cycle quarter-frame (`enable_240hz`) and half-frame (`enable_120hz`) strobes. It also raises the frame interrupt. It is configured by writes to register $4017 and sits between the register file and the pulse, triangle and noise channel blocks.

## Interface
- No parameters. Step positions are fixed constants for the 1.789773 MHz CPU clock.
- `clk` in 1: CPU-rate clock, 1.79 MHz, same clock as the channel timers.
- `rst_n` in 1: asynchronous, active-low reset.
- `reg_4017` in 8: frame-counter register value. Bit 7 is `mode` (0 = 4-step, 1 = 5-step). Bit 6 is `irq_inhibit`.
- `reg_event_4017` in 1: single-cycle strobe, high in the cycle `reg_4017` is written.
- `status_read` in 1: single-cycle strobe, high on a CPU read of $4015. Clears the IRQ.
- `enable_240hz` out 1: quarter-frame strobe, registered, one cycle wide.
- `enable_120hz` out 1: half-frame strobe, registered, one cycle wide.
- `frame_irq` out 1: frame interrupt flag, registered, level.
- `step` out 3: index of the most recent step, 0–4, registered. Debug use.

## Operation
- Internal state:
  - 16-bit `cycle_count`.
  - Latched `mode_q` and `inhibit_q`.
- Reset state: every output, `cycle_count`, `mode_q` and `inhibit_q` are 0.
- Counting: `cycle_count` increments by 1 every clk. It wraps to 0 on the cycle after it equals the period end.
- 4-step mode (`mode_q` = 0), period 29830:
  - Quarter strobes at `cycle_count` = 7456, 14912, 22370, 29828.
  - Half strobes at 14912 and 29828.
  - `cycle_count` = 29829 wraps to 0.
  - IRQ is set at 29828 when `inhibit_q` = 0.
- 5-step mode (`mode_q` = 1), period 37282:
  - Quarter strobes at 7456, 14912, 22370, 37280.
  - Half strobes at 14912 and 37280.
  - `cycle_count` = 37281 wraps to 0.
  - No IRQ in this mode.
- `step` takes the values 1, 2, 3, 4 at the four step points in either mode. It returns to 0 on wrap.
- Register write, `reg_event_4017` high in cycle W:
  - In cycle W+1, `cycle_count` = 0, `step` = 0, and `mode_q`/`inhibit_q` take bits 7/6.
  - If bit 7 = 1, both `enable_240hz` and `enable_120hz` pulse in W+1 (immediate clock).
  - If bit 6 = 1, `frame_irq` clears in W+1.
- IRQ clear: `status_read` or a write with `irq_inhibit` = 1 clears `frame_irq`.
- IRQ hold: `frame_irq` otherwise holds until cleared. It does not auto-clear on wrap.
- IRQ in 5-step mode: a write to 5-step mode does not clear an already-set `frame_irq` unless bit 6 = 1.

## Timing
- Strobe latency: strobes and the IRQ set are registered. A match at `cycle_count` = N appears on the outputs in the following cycle and lasts exactly one clk.
- Compare value: all comparisons use the current `cycle_count` and `mode_q`.
- Write vs. step match: if a write and a step match occur in the same cycle, the write wins. The match strobe and IRQ set are suppressed; only the write's immediate clock, if any, appears.
- `status_read` vs. IRQ set: if both occur in the same cycle, the set wins and `frame_irq` = 1 next cycle.
- Two back-to-back writes: the second write restarts the sequence again. Each write with bit 7 = 1 produces its own immediate strobe pair.
- `enable_120hz` is never high without `enable_240hz` in the same cycle.
- Reset mid-frame: asynchronous. All state clears immediately. Counting resumes from 0 on the first clk edge after `rst_n` rises.
- Counter width: the 16-bit counter never exceeds 37281. Any value above the period end, which cannot be reached but still needs defined behaviour, wraps to 0 on the next clk.
- Throughput: the block accepts one register event per clk and needs no handshake.

## Test plan
- **Reset default, 4-step:** release `rst_n` and run 60000 clks.
  - `enable_240hz` pulses on cycles 7457, 14913, 22371, 29829, then +29830 each frame.
  - `enable_120hz` pulses on 14913 and 29829.
  - `frame_irq` rises on 29829.
  - `step` reads 1..4.
- **5-step with immediate clock:** write `reg_4017` = 0x80 at cycle W.
  - Both strobes pulse at W+1.
  - Quarter strobes follow at W+1+7457, +14913, +22371, +37281.
  - Period is 37282.
  - `frame_irq` stays 0 for 3 frames.
- **IRQ clear paths:** let `frame_irq` set, then pulse `status_read`; the flag is 0 the next cycle.
  - Re-set the flag, then write 0x40; the flag is 0 at W+1 and never sets again.
- **Simultaneous events:** assert `status_read` in the same cycle as `cycle_count` = 29828; `frame_irq` = 1 afterwards.
  - Write 0x00 in the cycle `cycle_count` = 7456; no strobe appears, and the next quarter strobe is 7457 cycles later.
- **Asynchronous reset mid-frame:** assert `rst_n` low at cycle 10000 with `mode_q` = 1 and `frame_irq` = 1.
  - All outputs are 0 immediately, without waiting for a clk edge.
  - After release, the sequence matches the reset-default scenario.
